// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between execute control and the mul/div unit.
// master: issuing side; slave: muldiv_unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  modport master (
    output start, op, SrcA, SrcB, kill,
    input  busy, done, Result
  );

  modport slave (
    input  start, op, SrcA, SrcB, kill,
    output busy, done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add and restoring divide,
// one bit per cycle, sign handled by magnitude conversion.
module muldiv_unit #(
  parameter int unsigned EARLY_OUT = 1
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg;
  logic        spec;
  logic [31:0] spec_val;
  logic        done_q;
  logic [31:0] res_q;

  logic        is_div;
  logic        a_sgn;
  logic        b_sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_in;
  logic        div0;
  logic        ovf;
  logic        spec_in;
  logic [31:0] spec_val_in;

  always_comb begin
    is_div = bus.op[2];
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    unique case (1'b1)
      (bus.op == OP_MULH),
      (bus.op == OP_DIV),
      (bus.op == OP_REM): begin
        a_sgn = bus.SrcA[31];
        b_sgn = bus.SrcB[31];
      end
      (bus.op == OP_MULHSU): a_sgn = bus.SrcA[31];
      default: ;
    endcase
    a_mag  = a_sgn ? -bus.SrcA : bus.SrcA;
    b_mag  = b_sgn ? -bus.SrcB : bus.SrcB;
    // remainder follows the dividend; everything else follows sign xor
    neg_in = (is_div && bus.op[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div0   = is_div && (bus.SrcB == 32'd0);
    ovf    = is_div && !bus.op[0] &&
             (bus.SrcA == 32'h8000_0000) &&
             (bus.SrcB == 32'hFFFF_FFFF);
    spec_in = div0 || ovf;
    spec_val_in = 32'd0;
    unique case (1'b1)
      div0:    spec_val_in = bus.op[1] ? bus.SrcA : 32'hFFFF_FFFF;
      ovf:     spec_val_in = bus.op[1] ? 32'd0 : 32'h8000_0000;
      default: ;
    endcase
  end

  logic [32:0] mul_hi;
  logic [63:0] mul_nxt;
  logic [32:0] trial;
  logic [63:0] div_nxt;

  always_comb begin
    mul_hi  = {1'b0, acc[63:32]} +
              (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_nxt = {mul_hi, acc[31:1]};
    // acc holds {partial remainder, dividend/quotient}
    trial   = {acc[63:32], acc[31]} - {1'b0, opnd};
    div_nxt = trial[32] ? {acc[62:0], 1'b0}
                        : {trial[31:0], acc[30:0], 1'b1};
  end

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_nxt;

  always_comb begin
    prod_fix = neg ? -acc : acc;
    quo_fix  = neg ? -acc[31:0] : acc[31:0];
    rem_fix  = neg ? -acc[63:32] : acc[63:32];
    res_nxt  = 32'd0;
    unique case (op_q)
      OP_MUL:    res_nxt = prod_fix[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res_nxt = prod_fix[63:32];
      OP_DIV,
      OP_DIVU:   res_nxt = quo_fix;
      OP_REM,
      OP_REMU:   res_nxt = rem_fix;
      default:   res_nxt = 32'd0;
    endcase
    if (spec) res_nxt = spec_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_q     <= 3'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg      <= 1'b0;
      spec     <= 1'b0;
      spec_val <= 32'd0;
      done_q   <= 1'b0;
      res_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            op_q     <= bus.op;
            cnt      <= 5'd31;
            acc      <= is_div ? {32'd0, a_mag} : {32'd0, b_mag};
            opnd     <= is_div ? b_mag : a_mag;
            neg      <= neg_in;
            spec     <= spec_in;
            spec_val <= spec_val_in;
            state    <= ((EARLY_OUT != 0) && spec_in) ? FINISH : CALC;
          end
        end
        CALC: begin
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            acc <= op_q[2] ? div_nxt : mul_nxt;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!bus.kill) begin
            res_q  <= res_nxt;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, kill, reset,
// and early-out vs full-latency special cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1;
  logic        start0;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit_if m1 ();
  muldiv_unit_if m0 ();

  assign m1.start = start1;
  assign m1.op    = op;
  assign m1.SrcA  = a;
  assign m1.SrcB  = b;
  assign m1.kill  = kill;
  assign m0.start = start0;
  assign m0.op    = op;
  assign m0.SrcA  = a;
  assign m0.SrcB  = b;
  assign m0.kill  = 1'b0;

  muldiv_unit #(.EARLY_OUT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m1)
  );

  muldiv_unit #(.EARLY_OUT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m0)
  );

  // lat = edges after the start edge until done is seen, -1 on timeout
  task automatic run_op(input bit sel, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat,
                        output bit busy_ok);
    logic bs;
    logic dn;
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start0 = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    lat = -1;
    busy_ok = 1'b1;
    res = 32'hx;
    for (int i = 0; i < 100; i++) begin
      bs = sel ? m1.busy : m0.busy;
      dn = sel ? m1.done : m0.done;
      if (dn) begin
        lat = i;
        res = sel ? m1.Result : m0.Result;
        if (bs) busy_ok = 1'b0;
        break;
      end
      if (!bs) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    n_cmp++;
    if (m1.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b want 0", m1.busy);
    end
    n_cmp++;
    if (m1.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b want 0", m1.done);
    end
    n_cmp++;
    if (m1.Result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h want 0", m1.Result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int l;
    bit bo;
    run_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, r, l, bo);
    n_cmp++;
    if (r !== 32'hFFFF_FFEB) begin
      n_bad++;
      $display("FAIL mul_result: got %h want ffffffeb", r);
    end
    n_cmp++;
    if (l != 33) begin
      n_bad++;
      $display("FAIL mul_latency: got %0d want 33", l);
    end
    n_cmp++;
    if (bo !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_busy: got %b want 1", bo);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m1.done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: got %b want 0", m1.done);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'b011, 3'b001, 3'b010};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] r;
    int l;
    bit bo;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, bo);
      n_cmp++;
      if (r !== exp[i]) begin
        n_bad++;
        $display("FAIL mulh_%0d: got %h want %h", ops[i], r, exp[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'h7FFF_FFFC, 32'h0000_0001};
    logic [31:0] r;
    int l;
    bit bo;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, ops[i], 32'hFFFF_FFF9, 32'd2, r, l, bo);
      n_cmp++;
      if (r !== exp[i]) begin
        n_bad++;
        $display("FAIL div_%0d: got %h want %h", ops[i], r, exp[i]);
      end
      n_cmp++;
      if (l != 33) begin
        n_bad++;
        $display("FAIL div_lat_%0d: got %0d want 33", ops[i], l);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r;
    int l;
    bit bo;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        run_op(s == 1, ops[i], xa[i], xb[i], r, l, bo);
        n_cmp++;
        if (r !== exp[i]) begin
          n_bad++;
          $display("FAIL spec_e%0d_%0d: got %h want %h",
                   s, i, r, exp[i]);
        end
        n_cmp++;
        if (l != ((s == 1) ? 1 : 33)) begin
          n_bad++;
          $display("FAIL spec_lat_e%0d_%0d: got %0d want %0d",
                   s, i, l, (s == 1) ? 1 : 33);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int l;
    bit bo;
    run_op(1'b1, 3'b000, 32'd6, 32'd7, r, l, bo);
    n_cmp++;
    if (r !== 32'd42) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want 2a", r);
    end
    run_op(1'b1, 3'b101, 32'd42, 32'd5, r, l, bo);
    n_cmp++;
    if (r !== 32'd8) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want 8", r);
    end
    n_cmp++;
    if (l != 33) begin
      n_bad++;
      $display("FAIL b2b_latency: got %0d want 33", l);
    end
  endtask

  task automatic test_busy_kill();
    bit seen;
    @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd4; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd100; b = 32'd100; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m1.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (seen !== 1'b1 || m1.Result !== 32'd12) begin
      n_bad++;
      $display("FAIL ignore_start: got done=%b res=%h want 1 c",
               seen, m1.Result);
    end
    @(negedge clk);
    op = 3'b000; a = 32'd5; b = 32'd6; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    n_cmp++;
    if (m1.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_busy: got %b want 0", m1.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m1.done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_done: got %b want 0", seen);
    end
    n_cmp++;
    if (m1.Result !== 32'd12) begin
      n_bad++;
      $display("FAIL kill_result: got %h want c", m1.Result);
    end
    @(negedge clk);
    kill = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0; start1 = 1'b0;
    n_cmp++;
    if (m1.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_start_idle: got %b want 0", m1.busy);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int l;
    bit bo;
    @(negedge clk);
    op = 3'b100; a = 32'd1000; b = 32'd3; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m1.busy !== 1'b0 || m1.done !== 1'b0 ||
        m1.Result !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b done=%b res=%h want 0 0 0",
               m1.busy, m1.done, m1.Result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 3'b100, 32'd100, 32'd7, r, l, bo);
    n_cmp++;
    if (r !== 32'd14) begin
      n_bad++;
      $display("FAIL post_reset_div: got %h want e", r);
    end
  endtask

  initial begin
    start1 = 1'b0;
    start0 = 1'b0;
    kill   = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_busy_kill();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
